// File: rtl/mdio_master_if.sv
`default_nettype none
// ============================================================================
// Module      : mdio_master_if
// Description : Command/response bus between local PHY bring-up logic and the
//               Clause-22 MDIO master.
//   cmd_valid/cmd_ready : request handshake (accept = valid & ready)
//   cmd_write           : 1 = register write, 0 = register read
//   cmd_phy_addr        : 5-bit PHY address
//   cmd_reg_addr        : 5-bit register address
//   cmd_wdata           : 16-bit write data (ignored for reads)
//   rsp_valid           : one-cycle completion pulse for user commands
//   rsp_rdata           : last read data, held until the next read completes
//   rsp_err             : read turnaround sampled high (no PHY answered)
// Modports    : master = command issuer, slave = mdio_master
// Revision    : 1.0 - initial release
// ============================================================================
interface mdio_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [4:0]  cmd_phy_addr;
  logic [4:0]  cmd_reg_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/mdio_master.sv
`default_nettype none
// ============================================================================
// Module      : mdio_master
// Description : Clause-22 MDIO/SMI management master. Serialises single
//               register read/write commands into 64-bit management frames
//               (32 preamble, ST, OP, PHYAD, REGAD, TA, 16 data bits) and
//               returns read data.
// Ports       : clk      - system clock
//               reset_n  - synchronous, active-low reset
//               bus      - mdio_master_if.slave command/response bus
//               busy     - frame in progress
//               mdc      - management clock (held low when idle)
//               mdio_o   - serial data out
//               mdio_oe  - serial data output enable (0 = released)
//               mdio_i   - serial data in
//               link_up  - BMSR bit 2 from autopoll
// Parameters  : CLK_DIV     - clk cycles per MDC half-period (>= 2)
//               POLL_PHY    - PHY address used by autopoll
//               POLL_CYCLES - clk cycles between autopoll reads
// Options     : MDIO_AUTOPOLL_EN - when defined, periodically reads BMSR of
//               POLL_PHY while idle and reports link status on link_up;
//               when undefined there is no poll logic and link_up is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module mdio_master #(
  parameter int         CLK_DIV     = 10,
  parameter logic [4:0] POLL_PHY    = 5'd1,
  parameter int         POLL_CYCLES = 5_000_000
) (
  input  wire logic       clk,
  input  wire logic       reset_n,
  mdio_master_if.slave    bus,
  output logic            busy,
  output logic            mdc,
  output logic            mdio_o,
  output logic            mdio_oe,
  input  wire logic       mdio_i,
  output logic            link_up
);

  localparam int                DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Frame bit positions where the phase changes
  localparam logic [5:0] BIT_HDR  = 6'd32;
  localparam logic [5:0] BIT_TA   = 6'd46;
  localparam logic [5:0] BIT_TA2  = 6'd47;
  localparam logic [5:0] BIT_DATA = 6'd48;
  localparam logic [5:0] BIT_LAST = 6'd63;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_HDR  = 3'd2,
    S_TA   = 3'd3,
    S_DATA = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [5:0]        bit_cnt;
  logic [5:0]        next_bit;
  logic [62:0]       frame;      // frame bits 1..63, next bit at [62]
  logic              is_write;
  logic              is_poll;
  logic              ta_err;
  logic [15:0]       rd_shift;
  logic              rsp_valid_q;
  logic [15:0]       rsp_rdata_q;
  logic              rsp_err_q;
  logic              start_user;
  logic              start_poll;

  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = (state != S_IDLE);
  assign start_user    = (state == S_IDLE) && bus.cmd_valid;
  assign next_bit      = bit_cnt + 6'd1;

  // Bits 1..63 of a frame. Bit 0 is always a preamble '1' and is driven
  // directly at frame start. For reads the TA/data positions are don't-care
  // because the line is released; they are filled with '1'.
  function automatic logic [62:0] build_frame(
    input logic        wr,
    input logic [4:0]  phy,
    input logic [4:0]  rg,
    input logic [15:0] wd
  );
    build_frame = {31'h7FFF_FFFF, 2'b01, (wr ? 2'b01 : 2'b10), phy, rg,
                   2'b10, (wr ? wd : 16'hFFFF)};
  endfunction

`ifdef MDIO_AUTOPOLL_EN
  localparam int               TMR_W    = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(POLL_CYCLES - 1);

  logic [TMR_W-1:0] poll_timer;
  logic             link_up_q;

  // A user request in the expiry cycle wins; the timer then stays at its
  // terminal value so the poll starts on the next idle cycle without a request.
  assign start_poll = (state == S_IDLE) && !bus.cmd_valid && (poll_timer == TMR_LAST);
  assign link_up    = link_up_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      poll_timer <= '0;
    end else if ((state == S_IDLE) && !bus.cmd_valid) begin
      poll_timer <= start_poll ? '0 : poll_timer + 1'b1;
    end
  end
`else
  // No poll in this build; POLL_CYCLES only matters with autopoll and the
  // comparison is false for every legal setting.
  assign start_poll = (POLL_CYCLES < 0);
  assign link_up    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      frame       <= '1;
      is_write    <= 1'b0;
      is_poll     <= 1'b0;
      ta_err      <= 1'b0;
      rd_shift    <= '0;
      mdc         <= 1'b0;
      mdio_o      <= 1'b1;
      mdio_oe     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef MDIO_AUTOPOLL_EN
      link_up_q   <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          mdc     <= 1'b0;
          mdio_o  <= 1'b1;
          mdio_oe <= 1'b0;
          div_cnt <= '0;
          bit_cnt <= '0;
          if (start_user || start_poll) begin
            frame    <= start_user
                        ? build_frame(bus.cmd_write, bus.cmd_phy_addr,
                                      bus.cmd_reg_addr, bus.cmd_wdata)
                        : build_frame(1'b0, POLL_PHY, 5'd1, 16'hFFFF);
            is_write <= start_user && bus.cmd_write;
            is_poll  <= !start_user;
            mdio_o   <= 1'b1;   // bit 0: preamble
            mdio_oe  <= 1'b1;
            state    <= S_PRE;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin  // S_PRE, S_HDR, S_TA, S_DATA
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!mdc) begin
              // Rising MDC: capture the PHY's bit for the current position
              mdc <= 1'b1;
              if (bit_cnt == BIT_TA2) begin
                ta_err <= mdio_i;
              end
              if (state == S_DATA) begin
                rd_shift <= {rd_shift[14:0], mdio_i};
              end
            end else if (bit_cnt == BIT_LAST) begin
              mdc     <= 1'b0;
              mdio_o  <= 1'b1;
              mdio_oe <= 1'b0;
              state   <= S_DONE;
              if (is_poll) begin
`ifdef MDIO_AUTOPOLL_EN
                link_up_q <= !ta_err && rd_shift[2];
`endif
              end else begin
                rsp_valid_q <= 1'b1;
                if (is_write) begin
                  rsp_err_q <= 1'b0;
                end else begin
                  rsp_rdata_q <= rd_shift;
                  rsp_err_q   <= ta_err;
                end
              end
            end else begin
              // Falling MDC: present the next frame bit
              mdc     <= 1'b0;
              bit_cnt <= next_bit;
              mdio_o  <= frame[62];
              frame   <= {frame[61:0], 1'b1};
              mdio_oe <= is_write || (next_bit < BIT_TA);
              case (next_bit)
                BIT_HDR:  state <= S_HDR;
                BIT_TA:   state <= S_TA;
                BIT_DATA: state <= S_DATA;
                default:  ;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mdio_master.md
# mdio_master

Clause-22 MDIO/SMI management master that drives the `e_mdc`/`e_mdio` pins of the ethernet test top level toward the GMII PHY. It serialises single register read/write commands from local control logic into 64-bit management frames and returns read data. It sits between the top-level PHY bring-up logic and the PHY pins; the top level builds the `inout` from `mdio_o`/`mdio_oe`/`mdio_i`.

## Interface
Parameters:
- `CLK_DIV`, 10: clk cycles per MDC half-period. MDC = clk / (2·CLK_DIV); 2.5 MHz from 50 MHz. Legal range is ≥2.
- `POLL_PHY`, 5'd1: PHY address used by autopoll.
- `POLL_CYCLES`, 5_000_000: clk cycles between autopoll reads.

Ports:
- `clk`  in  1  system clock (`fpga_gclk`, 50 MHz)
- `reset_n`  in  1  synchronous, active-low
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  high only in IDLE; accept = valid & ready
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_phy_addr`  in  5  PHY address
- `cmd_reg_addr`  in  5  register address
- `cmd_wdata`  in  16  write data; ignored for reads
- `rsp_valid`  out  1  one-cycle pulse at end of a user command (read or write)
- `rsp_rdata`  out  16  read data; holds until next read completes
- `rsp_err`  out  1  read turnaround bit sampled 1 (no PHY); valid with `rsp_valid`
- `busy`  out  1  frame in progress
- `mdc`  out  1  management clock
- `mdio_o`  out  1  serial data out
- `mdio_oe`  out  1  output enable; 0 = released
- `mdio_i`  in  1  serial data in
- `link_up`  out  1  BMSR bit 2 from autopoll (see Configuration)

## Operation
- States: IDLE, PRE (32 bits), HDR (14 bits: ST `01`, OP `01` write / `10` read, PHYAD, REGAD, MSB first), TA (2 bits), DATA (16 bits, MSB first), DONE.
- Frame length is 64 bits. The shift counter steps once per MDC period.
- Write: `mdio_oe`=1 for all 64 bits. TA drives `10`, then `cmd_wdata`.
- Read: `mdio_oe`=1 through HDR. `mdio_oe`=0 from the first TA bit to the end of the frame.
  - Sample the second TA bit; a value of 1 sets `rsp_err`.
  - Shift 16 data bits into `rsp_rdata`. If no PHY responds, `rsp_rdata` = 0xFFFF via pull-up.
- Command fields are latched at accept. Input changes during `busy` are ignored.
- DONE: `mdc`=0, `mdio_oe`=0, `rsp_valid`=1 for one cycle (user commands only), then IDLE.
- `cmd_valid` during `busy`: `cmd_ready`=0 and nothing is accepted. The request is taken on the first IDLE cycle.

## Timing
- Reset values: `mdc`=0, `mdio_o`=1, `mdio_oe`=0, `cmd_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `link_up`=0, state IDLE, poll timer 0.
- The accept cycle is A. Frame bit k is presented on `mdio_o` from cycle A+1+2k·CLK_DIV, with `mdc` low for CLK_DIV cycles and then high for CLK_DIV cycles.
- `mdio_o`/`mdio_oe` change only when `mdc` goes low (or at frame start).
- `mdio_i` is sampled in the cycle in which `mdc` goes 0→1.
- `rsp_valid` fires at cycle A+1+128·CLK_DIV. `cmd_ready` returns high the next cycle.
- `mdc` is held low in IDLE. There is no free-running MDC.
- Reset asserted mid-frame: all outputs return to their reset values on the next clk edge. The partial frame is abandoned and no `rsp_valid` is produced.

## Configuration
- `MDIO_AUTOPOLL_EN` defined:
  - The poll timer counts in IDLE.
  - When it reaches POLL_CYCLES-1 and `cmd_valid`=0, the block runs a read of POLL_PHY reg 1 and clears the timer.
  - `cmd_ready`=0 during the poll.
  - On completion, `link_up` <= data bit 2, or 0 if `rsp_err`.
  - A poll produces no `rsp_valid` and does not update `rsp_rdata`/`rsp_err`.
  - User `cmd_valid` in the same cycle as timer expiry wins. The poll is deferred to the next IDLE cycle.
- Undefined: the timer and poll logic are absent and `link_up` is tied 0.

## Test plan
- Write, CLK_DIV=2, PHY 1, reg 0, data 0x1140 -> `mdio_o` stream is 32×1, `0101`, `00001`, `00000`, `10`, `0001000101000000`; `mdio_oe`=1 throughout; `rsp_valid` at A+257.
- Read, PHY 1, reg 2, with a PHY model driving TA=0 and data 0x004D -> `mdio_oe` drops at bit 46; `rsp_rdata`=0x004D, `rsp_err`=0.
- Read with `mdio_i` held 1 (no PHY) -> `rsp_err`=1, `rsp_rdata`=0xFFFF.
- `cmd_valid` held high continuously with two queued commands -> second accept occurs exactly one cycle after the first `rsp_valid`; no fields are corrupted.
- Reset pulse at bit 40 of a read -> next cycle: `mdc`=0, `mdio_oe`=0, `busy`=0, `rsp_valid` never asserts; a following write completes normally.
- `MDIO_AUTOPOLL_EN`, POLL_CYCLES=100, PHY model BMSR=0x796D -> `link_up`=1 after the first poll; with BMSR=0x7969, `link_up`=0; no `rsp_valid` pulses during either poll.
